// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use stalls, taken-branch flushes and
// multi-cycle EX residency, plus a saturating count of stalled cycles.
module pipeline_stall_ctrl #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_Rt,
  input  logic        EX_MulOp,
  input  logic        BranchTaken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IDEX_Write,
  output logic        EXMEM_Write,
  output logic        MEMWB_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Flush,
  output logic        EXMEM_Flush,
  output logic [15:0] StallCount
);

  typedef enum logic {StRun, StMul} state_e;

  localparam logic       MulEnable = (MUL_CYCLES > 1);
  localparam logic [3:0] CntInit   = 4'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);

  state_e      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [15:0] r_stall_count;
  logic        w_lu;
  logic        w_mul_stall;

  assign w_lu = EX_MemRead && (EX_Rt != 5'd0) &&
                ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

  // Stall while entering MUL and for every MUL cycle with Cnt still nonzero.
  assign w_mul_stall = ((r_state == StRun) && EX_MulOp && MulEnable) ||
                       ((r_state == StMul) && (r_cnt != 4'd0));

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IDEX_Write   = 1'b1;
    EXMEM_Write  = 1'b1;
    MEMWB_Write  = 1'b1;
    IFID_Flush   = 1'b0;
    IDEX_Flush   = 1'b0;
    EXMEM_Flush  = 1'b0;

    unique case (r_state)
      StRun: begin
        if (w_mul_stall) begin
          w_state_next = StMul;
          w_cnt_next   = CntInit;
        end else if (BranchTaken) begin
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end else if (w_lu) begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IDEX_Flush = 1'b1;
        end
      end
      StMul: begin
        if (w_mul_stall) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_state_next = StRun;
        end
      end
      default: w_state_next = StRun;
    endcase

    if (w_mul_stall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Flush = 1'b1;
    end

    // Reset is asynchronous, so the enables must drop before any clock edge arrives.
    if (!Rst) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state       <= StRun;
      r_cnt         <= 4'd0;
      r_stall_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!PCWrite && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
    end
  end

  assign StallCount = r_stall_count;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized plus directed bench for pipeline_stall_ctrl; a cycle-level reference model feeds a
// scoreboard queue that a negedge monitor drains against the DUT outputs.
module tb_pipeline_stall_ctrl;

  localparam int unsigned MulCycles = 4;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [4:0]  ID_Rs = '0, ID_Rt = '0, EX_Rt = '0;
  logic        ID_UsesRt = 1'b0, EX_MemRead = 1'b0, EX_MulOp = 1'b0, BranchTaken = 1'b0;
  logic        PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
  logic        IFID_Flush, IDEX_Flush, EXMEM_Flush;
  logic [15:0] StallCount;

  pipeline_stall_ctrl #(.MUL_CYCLES(MulCycles)) u_dut (
    .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt), .EX_MulOp(EX_MulOp), .BranchTaken(BranchTaken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
    .EXMEM_Write(EXMEM_Write), .MEMWB_Write(MEMWB_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush), .StallCount(StallCount)
  );

  always #5 Clk = ~Clk;

  // {PCWrite, IFID_W, IDEX_W, EXMEM_W, MEMWB_W, IFID_F, IDEX_F, EXMEM_F}
  localparam logic [7:0] OutDefault = 8'b1111_1000;
  localparam logic [7:0] OutMul     = 8'b0001_1001;
  localparam logic [7:0] OutBranch  = 8'b1111_1110;
  localparam logic [7:0] OutLu      = 8'b0011_1010;
  localparam logic [7:0] OutReset   = 8'b0000_0000;

  typedef struct {
    logic [7:0]  ctl;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done   = 0;

  // Reference model state: stall cycles still owed to the current multi-cycle op,
  // whether the release cycle is pending, and the stall total.
  int   m_mul_left = 0;
  bit   m_release  = 0;
  int   m_count    = 0;

  task automatic drive(input bit rst, input bit mem_rd, input int ex_rt, input int rs,
                       input int rt, input bit uses_rt, input bit mul, input bit br,
                       input string tag);
    exp_t e;
    bit   lu;
    @(posedge Clk);
    #1;
    Rst = rst; EX_MemRead = mem_rd; EX_Rt = 5'(ex_rt); ID_Rs = 5'(rs); ID_Rt = 5'(rt);
    ID_UsesRt = uses_rt; EX_MulOp = mul; BranchTaken = br;
    lu = mem_rd && ex_rt != 0 && (ex_rt == rs || (uses_rt && ex_rt == rt));
    e.tag = tag;
    if (!rst) begin
      m_mul_left = 0; m_release = 0; m_count = 0;
      e.ctl = OutReset; e.cnt = 16'd0;
    end else begin
      e.cnt = 16'(m_count);
      if (m_mul_left > 0) begin
        e.ctl = OutMul;
        m_mul_left--;
        if (m_mul_left == 0) m_release = 1;
      end else if (m_release) begin
        e.ctl = OutDefault;
        m_release = 0;
      end else if (mul && MulCycles > 1) begin
        e.ctl = OutMul;
        m_mul_left = MulCycles - 2;
        if (m_mul_left == 0) m_release = 1;
      end else if (br) begin
        e.ctl = OutBranch;
      end else if (lu) begin
        e.ctl = OutLu;
      end else begin
        e.ctl = OutDefault;
      end
      if (!e.ctl[7] && m_count < 65535) m_count++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input string tag);
    drive(1, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = q.pop_front();
      act = {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
             IFID_Flush, IDEX_Flush, EXMEM_Flush};
      checks++;
      if (act !== e.ctl) begin
        errors++;
        $display("FAIL %s ctl: got %b expected %b", e.tag, act, e.ctl);
      end
      checks++;
      if (StallCount !== e.cnt) begin
        errors++;
        $display("FAIL %s StallCount: got %h expected %h", e.tag, StallCount, e.cnt);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, "reset");
    drive(0, 1, 8, 8, 0, 0, 0, 0, "reset_hold");
    idle("post_reset");

    // Load-use on rs: exactly one stall cycle, count 0 -> 1.
    drive(1, 1, 8, 8, 3, 0, 0, 0, "lu_rs");
    idle("lu_after");
    // Zero register and unused rt never stall.
    drive(1, 1, 0, 0, 0, 1, 0, 0, "lu_zero");
    drive(1, 1, 9, 3, 9, 0, 0, 0, "rt_unused");
    drive(1, 1, 9, 3, 9, 1, 0, 0, "lu_rt");
    // Branch beats load-use.
    drive(1, 1, 8, 8, 8, 1, 0, 1, "br_vs_lu");
    // Multi-cycle op held: 3 stalls then release, then a fresh sequence back-to-back.
    for (int i = 0; i < 9; i++) drive(1, (i == 4), 8, 8, 0, 0, 1, (i == 2), "mul_held");
    idle("mul_done");
    // Reset during the second stall cycle abandons the sequence.
    drive(1, 0, 0, 0, 0, 0, 1, 0, "mul_pre_rst");
    drive(0, 0, 0, 0, 0, 0, 1, 0, "mul_rst");
    drive(1, 0, 0, 0, 0, 0, 0, 0, "mul_rst_rel");
    idle("mul_rst_run");

    for (int i = 0; i < 3000; i++) begin
      bit mul = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 199) != 0), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), mul,
            ($urandom_range(0, 5) == 0), "random");
    end

    // Saturation: continuous load-use hazard from a clean count.
    drive(0, 0, 0, 0, 0, 0, 0, 0, "sat_reset");
    for (int i = 0; i < 65534 + 3; i++) drive(1, 1, 5, 5, 0, 0, 0, 0, "sat");
    idle("sat_hold");
    idle("sat_hold2");

    repeat (3) @(posedge Clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    checks++;
    if (StallCount !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_final: got %h expected ffff", StallCount);
    end
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    if (!done) begin
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
    end
  end

endmodule
